// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy memory-bus initiator: FSM encoding,
// memory-mapped peripheral addresses and the word step used by the pointers.
package dma_pkg;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dma_state_t;

   localparam logic [31:0] SW_ADDR   = 32'hC000_0000;
   localparam logic [31:0] LED_ADDR  = 32'hC000_0004;
   localparam logic [31:0] WORD_STEP = 32'd4;
endpackage

// File: rtl/dma_ptr.sv
// Word-aligned 32-bit address pointer: loads with the low two bits cleared and
// advances by one word; wraps modulo 2^32.
module dma_ptr
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        inc,
   output logic [31:0] ptr
);
   logic [31:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (load)
         ptr_d = load_val & ~32'd3;
      else if (inc)
         ptr_d = ptr_q + WORD_STEP;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
endmodule

// File: rtl/dma_copy.sv
// Block copy engine on the shared data-memory bus: one read then one write per
// word, stalling whenever bus_gnt is low. Define DMA_COPY_IRQ_EN for irq/irq_ack.
module dma_copy
   import dma_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   input  logic             bus_gnt,
   output logic             busy,
   output logic             done,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd
`ifdef DMA_COPY_IRQ_EN
   ,
   output logic             irq,
   input  logic             irq_ack
`endif
);
   dma_state_t       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      src_ptr, dst_ptr;
   logic             ptr_ld, src_inc, dst_inc;

   assign ptr_ld  = (state_q == IDLE) && start;
   assign src_inc = (state_q == READ) && bus_gnt;
   assign dst_inc = (state_q == WRITE) && bus_gnt;

   dma_ptr u_src_ptr (
      .clk      (clk),
      .reset    (reset),
      .load     (ptr_ld),
      .load_val (src),
      .inc      (src_inc),
      .ptr      (src_ptr)
   );

   dma_ptr u_dst_ptr (
      .clk      (clk),
      .reset    (reset),
      .load     (ptr_ld),
      .load_val (dst),
      .inc      (dst_inc),
      .ptr      (dst_ptr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      mem_we  = 1'b0;
      mem_a   = '0;
      mem_wd  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = len;
               state_d = (len != '0) ? READ : DONE;
            end
         end
         READ: begin
            mem_a = src_ptr;
            if (bus_gnt) begin
               data_d  = mem_rd;
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_a  = dst_ptr;
            mem_wd = data_q;
            mem_we = bus_gnt;
            if (bus_gnt) begin
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

`ifdef DMA_COPY_IRQ_EN
   logic irq_q, irq_d;

   // Set is asserted both entering and leaving DONE so an ack overlapping
   // completion can never swallow the new interrupt.
   always_comb begin
      irq_d = irq_q;
      if (irq_ack)
         irq_d = 1'b0;
      if ((state_d == DONE) || (state_q == DONE))
         irq_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         irq_q <= 1'b0;
      else
         irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif
endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: table of copy jobs checked for timing,
// plus a write scoreboard fed from a behavioural memory with switch/LED ports.
`timescale 1ns/1ps
module tb_dma_copy;
   import dma_pkg::*;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      src = '0;
   logic [31:0]      dst = '0;
   logic [LEN_W-1:0] len = '0;
   logic             bus_gnt = 1'b1;
   logic             busy, done, mem_we;
   logic [31:0]      mem_a, mem_wd, mem_rd;
`ifdef DMA_COPY_IRQ_EN
   logic             irq;
   logic             irq_ack = 1'b0;
`endif

   logic [31:0] ram [0:63];
   logic [31:0] switches;
   logic [31:0] leds;

   int total = 0;
   int bad   = 0;

   logic [31:0] sb_addr [$];
   logic [31:0] sb_data [$];

   typedef struct {
      logic [31:0]      s;
      logic [31:0]      d;
      logic [LEN_W-1:0] n;
      int               mode;   // 0: grant always, 1: grant only on even cycles
      int               poke;   // cycle at which a stray start is pulsed (0 = none)
      int               exp;    // cycle of done and number of busy cycles
   } vec_t;

   vec_t vecs [7];

   dma_copy #(.LEN_W(LEN_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .src     (src),
      .dst     (dst),
      .len     (len),
      .bus_gnt (bus_gnt),
      .busy    (busy),
      .done    (done),
      .mem_we  (mem_we),
      .mem_a   (mem_a),
      .mem_wd  (mem_wd),
      .mem_rd  (mem_rd)
`ifdef DMA_COPY_IRQ_EN
      ,
      .irq     (irq),
      .irq_ack (irq_ack)
`endif
   );

   always #5 clk = ~clk;

   assign mem_rd = (mem_a == SW_ADDR) ? switches :
                   (mem_a < 32'd256)  ? ram[mem_a[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_a == LED_ADDR)
            leds <= mem_wd;
         else if (mem_a < 32'd256)
            ram[mem_a[7:2]] <= mem_wd;
      end
   end

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a == SW_ADDR)
         return switches;
      else if (a < 32'd256)
         return ram[a[7:2]];
      else
         return 32'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Every committed write must match the next expected {addr, data}.
   always @(negedge clk) begin
      #2;
      if (mem_we) begin
         if (sb_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_a, mem_wd);
         end else begin
            chk("wr_addr", mem_a, sb_addr.pop_front());
            chk("wr_data", mem_wd, sb_data.pop_front());
            chk("we_gnt", {31'd0, bus_gnt}, 32'd1);
         end
      end
   end

   task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         sb_addr.push_back((d & ~32'd3) + 32'(4 * i));
         sb_data.push_back(model_rd((s & ~32'd3) + 32'(4 * i)));
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int done_at;
      int busy_cnt;
      int pulses;
      int k;
      done_at  = -1;
      busy_cnt = 0;
      pulses   = 0;
      push_exp(v.s, v.d, int'(v.n));
      @(negedge clk);
      start   = 1'b1;
      src     = v.s;
      dst     = v.d;
      len     = v.n;
      bus_gnt = 1'b1;
      @(posedge clk);
      k = 0;
      while (k < 200) begin
         k++;
         @(negedge clk);
         start = (v.poke != 0 && k == v.poke);
         if (start) begin
            src = 32'h20;
            dst = 32'h80;
            len = 8'd2;
         end
         bus_gnt = (v.mode == 0) ? 1'b1 : (k % 2 == 0);
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            pulses++;
            if (done_at < 0) done_at = k;
         end
         if (done_at >= 0 && k >= done_at + 3) break;
      end
      start   = 1'b0;
      bus_gnt = 1'b1;
      chk($sformatf("v%0d_done_cycle", idx), 32'(done_at), 32'(v.exp));
      chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.exp));
      chk($sformatf("v%0d_done_pulses", idx), 32'(pulses), 32'd1);
      chk($sformatf("v%0d_sb_drained", idx), 32'(sb_addr.size()), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h00, 32'h40, 8'd4, 0, 0, 9};
      vecs[1] = '{32'h00, 32'h40, 8'd4, 1, 0, 17};
      vecs[2] = '{SW_ADDR, LED_ADDR, 8'd1, 0, 0, 3};
      vecs[3] = '{32'h00, 32'h80, 8'd0, 0, 0, 1};
      vecs[4] = '{32'h03, 32'h60, 8'd2, 0, 0, 5};
      vecs[5] = '{32'h20, 32'hA0, 8'd3, 1, 0, 13};
      vecs[6] = '{32'h00, 32'hC0, 8'd4, 0, 3, 9};

      for (int i = 0; i < 64; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
      ram[0]  = 32'd11;
      ram[1]  = 32'd22;
      ram[2]  = 32'd33;
      ram[3]  = 32'd44;
      ram[8]  = 32'h100;
      ram[9]  = 32'h200;
      ram[10] = 32'h300;
      switches = 32'h2A5;
      leds     = 32'h0;

      #12;
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_we",     {31'd0, mem_we}, 32'd0);
      chk("rst_mem_a",  mem_a,           32'd0);
      chk("rst_mem_wd", mem_wd,          32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      chk("ram16", ram[16], 32'd11);
      chk("ram17", ram[17], 32'd22);
      chk("ram18", ram[18], 32'd33);
      chk("ram19", ram[19], 32'd44);
      chk("leds",  leds,    32'h2A5);
      chk("ram24_unaligned_src", ram[24], 32'd11);
      chk("ram25_unaligned_src", ram[25], 32'd22);
      chk("ram42", ram[42], 32'h300);
      chk("ram32_untouched", ram[32], 32'hDEAD_0020);
      chk("ram51", ram[51], 32'd44);

      // Abort a 4-word copy to 0xE0 during the second write.
      push_exp(32'h00, 32'hE0, 4);
      @(negedge clk);
      start = 1'b1; src = 32'h00; dst = 32'hE0; len = 8'd4; bus_gnt = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 4) reset = 1'b0;
      end
      #1;
      chk("abort_busy",   {31'd0, busy},   32'd0);
      chk("abort_done",   {31'd0, done},   32'd0);
      chk("abort_we",     {31'd0, mem_we}, 32'd0);
      chk("abort_mem_a",  mem_a,           32'd0);
      chk("abort_mem_wd", mem_wd,          32'd0);
      chk("abort_sb_left", 32'(sb_addr.size()), 32'd3);
      sb_addr.delete();
      sb_data.delete();
      repeat (2) @(negedge clk);
      chk("abort_done_held", {31'd0, done}, 32'd0);
      reset = 1'b1;
      chk("abort_ram56", ram[56], 32'd11);
      chk("abort_ram57", ram[57], 32'hDEAD_0039);
      chk("abort_ram59", ram[59], 32'hDEAD_003B);
      run_vec('{32'h00, 32'hE0, 8'd4, 0, 0, 9}, 7);
      chk("restart_ram59", ram[59], 32'd44);

`ifdef DMA_COPY_IRQ_EN
      chk("irq_pending", {31'd0, irq}, 32'd1);
      @(negedge clk); irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      start = 1'b1; src = 32'h0; dst = 32'h80; len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      irq_ack = 1'b1;
      chk("irq_with_done", {31'd0, irq}, 32'd1);
      chk("irq_done_cycle", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("irq_set_wins", {31'd0, irq}, 32'd1);
      @(negedge clk);
      chk("irq_acked", {31'd0, irq}, 32'd0);
      irq_ack = 1'b0;
`endif

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
